// File: rtl/rhythm_pkg.sv
// rtl/rhythm_pkg.sv - shared state encoding and key codes for the rhythm lanes
//
// Contents:
//   lane_state_t : per-lane FSM states (IDLE, WAIT, FALL, DONE)
//   KEY_START    : key code that starts a run
//   KEY_RESTART  : key code that returns a finished lane to IDLE
//   KEY_LANE0    : hit key for the first lane
package rhythm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    FALL = 2'd2,
    DONE = 2'd3
  } lane_state_t;

  localparam logic [7:0] KEY_START   = 8'h2c;
  localparam logic [7:0] KEY_RESTART = 8'h01;
  localparam logic [7:0] KEY_LANE0   = 8'h51;

endpackage

// File: rtl/dropper_lane_key_edge.sv
// rtl/dropper_lane_key_edge.sv - fresh-press detector for one lane key
//
// Ports:
//   frame_clk      in   frame clock
//   Reset          in   synchronous active-low reset (clears key history)
//   keycode        in   first current key code
//   keycode_second in   second current key code
//   key_press      out  lane key seen on either code this frame but not last frame
module key_edge
  import rhythm_pkg::*;
#(
  parameter logic [7:0] KEY = KEY_LANE0
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic [7:0] keycode_second,
  output logic       key_press
);

  logic match;
  logic match_q;

  assign match = (keycode == KEY) || (keycode_second == KEY);

  // History advances every frame regardless of lane state, so a key held
  // across a WAIT period still counts as held when the note appears.
  always_ff @(posedge frame_clk) begin
    if (!Reset) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match;
    end
  end

  assign key_press = match && !match_q;

endmodule

// File: rtl/dropper_lane.sv
// rtl/dropper_lane.sv - one falling-note lane: spawn, fall, score hit or miss
//
// Ports:
//   frame_clk       in   frame clock, sole clock
//   Reset           in   synchronous active-low reset
//   keycode         in   first current key code (also START/RESTART)
//   keycode_second  in   second current key code (hit key only)
//   dropX, dropY    out  note top-left position
//   visible         out  note is drawn (lane is falling)
//   hit, miss       out  one-frame scoring pulses
//   hit_count       out  hits this run
//   miss_count      out  misses this run
//   done            out  all notes of the run resolved
module dropper_lane
  import rhythm_pkg::*;
#(
  parameter int         X_START     = 560,
  parameter int         Y_START     = 100,
  parameter int         Y_MAX       = 400,
  parameter int         H           = 40,
  parameter int         HIT_LO      = 340,
  parameter int         HIT_HI      = 400,
  parameter int         SPEED       = 1,
  parameter int         DELAY       = 640,
  parameter int         SPACING     = 80,
  parameter int         NUM_NOTES   = 4,
  parameter logic [7:0] HIT_KEY     = KEY_LANE0,
  parameter logic [7:0] START_KEY   = KEY_START,
  parameter logic [7:0] RESTART_KEY = KEY_RESTART,
  localparam int        CW          = $clog2(NUM_NOTES + 1)
) (
  input  logic          frame_clk,
  input  logic          Reset,
  input  logic [7:0]    keycode,
  input  logic [7:0]    keycode_second,
  output logic [9:0]    dropX,
  output logic [9:0]    dropY,
  output logic          visible,
  output logic          hit,
  output logic          miss,
  output logic [CW-1:0] hit_count,
  output logic [CW-1:0] miss_count,
  output logic          done
);

  lane_state_t   state;
  logic [11:0]   cnt;
  logic [11:0]   wait_len;
  logic [CW-1:0] note_idx;
  logic          key_press;
  logic [10:0]   bottom;
  logic          miss_now;
  logic          hit_now;

  key_edge #(
    .KEY(HIT_KEY)
  ) u_key_edge (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .keycode       (keycode),
    .keycode_second(keycode_second),
    .key_press     (key_press)
  );

  // Bottom edge one bit wider than dropY so a note near the screen edge
  // cannot wrap back into the hit window.
  assign bottom   = {1'b0, dropY} + 11'(H);
  // The miss line wins over a simultaneous press.
  assign miss_now = (bottom >= 11'(Y_MAX));
  assign hit_now  = !miss_now && key_press &&
                    (bottom >= 11'(HIT_LO)) && (bottom < 11'(HIT_HI));

  always_ff @(posedge frame_clk) begin
    if (!Reset) begin
      state      <= IDLE;
      dropY      <= 10'(Y_START);
      cnt        <= '0;
      wait_len   <= 12'(DELAY);
      note_idx   <= '0;
      hit        <= 1'b0;
      miss       <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      hit  <= 1'b0;
      miss <= 1'b0;
      unique case (state)
        IDLE: begin
          if (keycode == START_KEY) begin
            state      <= WAIT;
            wait_len   <= 12'(DELAY);
            cnt        <= '0;
            note_idx   <= '0;
            hit_count  <= '0;
            miss_count <= '0;
            dropY      <= 10'(Y_START);
          end
        end
        WAIT: begin
          if (cnt == wait_len - 12'd1) begin
            state <= FALL;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 12'd1;
          end
        end
        FALL: begin
          if (miss_now) begin
            miss       <= 1'b1;
            miss_count <= miss_count + CW'(1);
          end else if (hit_now) begin
            hit       <= 1'b1;
            hit_count <= hit_count + CW'(1);
          end else begin
            dropY <= dropY + 10'(SPEED);
          end
          if (miss_now || hit_now) begin
            if (note_idx == CW'(NUM_NOTES - 1)) begin
              state <= DONE;
            end else begin
              note_idx <= note_idx + CW'(1);
              dropY    <= 10'(Y_START);
              wait_len <= 12'(SPACING);
              cnt      <= '0;
              state    <= WAIT;
            end
          end
        end
        DONE: begin
          if (keycode == RESTART_KEY) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dropX   = 10'(X_START);
  assign visible = (state == FALL);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_dropper_lane.sv
// tb/tb_dropper_lane.sv - self-checking bench for dropper_lane
module tb_dropper_lane;

  localparam int Y_START = 100;
  localparam int Y_MAX   = 400;
  localparam int H       = 40;
  localparam int HIT_LO  = 340;
  localparam int HIT_HI  = 400;
  localparam int SPEED   = 1;
  localparam int DELAY   = 640;
  localparam int SPACING = 80;
  localparam int NUM     = 4;

  localparam int P_IDLE = 0;
  localparam int P_WAIT = 1;
  localparam int P_FALL = 2;
  localparam int P_DONE = 3;

  logic       frame_clk;
  logic       Reset;
  logic [7:0] keycode;
  logic [7:0] keycode_second;
  logic [9:0] dropX;
  logic [9:0] dropY;
  logic       visible;
  logic       hit;
  logic       miss;
  logic [2:0] hit_count;
  logic [2:0] miss_count;
  logic       done;

  int checks = 0;
  int errors = 0;

  // Reference model: the note position is derived from the frame at which
  // the note started falling, not from a running register.
  int m_frame      = 0;
  int m_phase      = P_IDLE;
  int m_fall_at    = 0;
  int m_fall_start = 0;
  int m_y          = Y_START;
  int m_hits       = 0;
  int m_misses     = 0;
  int m_notes      = 0;
  bit m_prev       = 0;
  bit m_hit        = 0;
  bit m_miss       = 0;

  dropper_lane dut (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .keycode       (keycode),
    .keycode_second(keycode_second),
    .dropX         (dropX),
    .dropY         (dropY),
    .visible       (visible),
    .hit           (hit),
    .miss          (miss),
    .hit_count     (hit_count),
    .miss_count    (miss_count),
    .done          (done)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [7:0] k1, input logic [7:0] k2, input logic rst_n);
    bit m;
    bit kp;
    bit resolved;
    int y_pre;
    m      = (k1 == 8'h51) || (k2 == 8'h51);
    kp     = m && !m_prev;
    m_hit  = 0;
    m_miss = 0;
    if (!rst_n) begin
      m_prev   = 0;
      m_phase  = P_IDLE;
      m_y      = Y_START;
      m_hits   = 0;
      m_misses = 0;
      m_notes  = 0;
    end else begin
      m_prev = m;
      case (m_phase)
        P_IDLE: if (k1 == 8'h2c) begin
          m_phase   = P_WAIT;
          m_fall_at = m_frame + DELAY;
          m_y       = Y_START;
          m_hits    = 0;
          m_misses  = 0;
          m_notes   = 0;
        end
        P_WAIT: if (m_frame == m_fall_at) begin
          m_phase      = P_FALL;
          m_fall_start = m_frame;
        end
        P_FALL: begin
          y_pre    = Y_START + (m_frame - 1 - m_fall_start) * SPEED;
          resolved = 0;
          if (y_pre + H >= Y_MAX) begin
            m_miss = 1; m_misses++; resolved = 1;
          end else if (kp && (y_pre + H >= HIT_LO) && (y_pre + H < HIT_HI)) begin
            m_hit = 1; m_hits++; resolved = 1;
          end
          m_y = y_pre + SPEED;
          if (resolved) begin
            m_notes++;
            if (m_notes == NUM) begin
              m_phase = P_DONE;
              m_y     = y_pre;
            end else begin
              m_phase   = P_WAIT;
              m_fall_at = m_frame + SPACING;
              m_y       = Y_START;
            end
          end
        end
        default: if (k1 == 8'h01) m_phase = P_IDLE;
      endcase
    end
    m_frame++;
  endtask

  task automatic check_all();
    check("dropX", dropX, 560);
    check("dropY", dropY, m_y);
    check("visible", visible, m_phase == P_FALL);
    check("done", done, m_phase == P_DONE);
    check("hit", hit, m_hit);
    check("miss", miss, m_miss);
    check("hit_count", hit_count, m_hits);
    check("miss_count", miss_count, m_misses);
  endtask

  task automatic step(input logic [7:0] k1, input logic [7:0] k2, input logic rst_n);
    keycode        = k1;
    keycode_second = k2;
    Reset          = rst_n;
    @(posedge frame_clk);
    model_edge(k1, k2, rst_n);
    #1;
    check_all();
  endtask

  task automatic steer_to(input int y);
    int n;
    n = 0;
    while (!(m_phase == P_FALL && m_y == y) && n < 2000) begin
      step(8'h00, 8'h00, 1'b1);
      n++;
    end
    check("steer_dropY", dropY, y);
    check("steer_visible", visible, 1);
  endtask

  function automatic logic [7:0] pick_key();
    int r;
    r = $urandom_range(0, 99);
    if (r < 70) return 8'h00;
    if (r < 88) return 8'h51;
    if (r < 93) return 8'h2c;
    if (r < 97) return 8'h01;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    logic [7:0] k1;
    logic [7:0] k2;
    logic       rn;
    int         n;
    keycode        = 8'h00;
    keycode_second = 8'h00;
    Reset          = 1'b0;

    // Reset state
    step(8'h00, 8'h00, 1'b0);
    step(8'h00, 8'h00, 1'b0);
    check("rst_dropY", dropY, 100);
    check("rst_counts", {hit_count, miss_count}, 0);

    // Start: 640 frames invisible, then falling from 100 at +1 per frame
    step(8'h2c, 8'h00, 1'b1);
    for (int i = 0; i < 639; i++) step(8'h00, 8'h00, 1'b1);
    check("delay_still_hidden", visible, 0);
    step(8'h00, 8'h00, 1'b1);
    check("first_visible", visible, 1);
    check("first_dropY", dropY, 100);
    step(8'h00, 8'h00, 1'b1);
    check("second_dropY", dropY, 101);

    // Note 1: no keys, miss at 360, then 80 hidden frames
    steer_to(360);
    step(8'h00, 8'h00, 1'b1);
    check("miss_pulse", miss, 1);
    check("miss_count_1", miss_count, 1);
    check("miss_hidden", visible, 0);
    for (int i = 0; i < 79; i++) step(8'h00, 8'h00, 1'b1);
    check("spacing_hidden", visible, 0);
    step(8'h00, 8'h00, 1'b1);
    check("respawn_visible", visible, 1);
    check("respawn_dropY", dropY, 100);

    // Note 2: press at 299 is just outside the window
    steer_to(299);
    step(8'h51, 8'h00, 1'b1);
    check("early_no_hit", hit, 0);
    check("early_dropY", dropY, 300);
    step(8'h00, 8'h00, 1'b1);
    steer_to(305);
    step(8'h51, 8'h00, 1'b1);
    check("late_hit", hit, 1);
    check("hit_count_1", hit_count, 1);
    step(8'h00, 8'h00, 1'b1);

    // Note 3: fresh press exactly at 300
    steer_to(300);
    step(8'h51, 8'h00, 1'b1);
    check("edge_hit", hit, 1);
    check("hit_count_2", hit_count, 2);
    step(8'h00, 8'h00, 1'b1);

    // Note 4: key held from 290 never scores, ends in a miss
    steer_to(290);
    n = 0;
    while (m_y != 360 && n < 200) begin
      step(8'h51, 8'h00, 1'b1);
      n++;
    end
    check("held_dropY", dropY, 360);
    step(8'h51, 8'h00, 1'b1);
    check("held_miss", miss, 1);
    check("held_hit_count", hit_count, 2);
    check("run_done", done, 1);
    check("run_hidden", visible, 0);

    // Restart holds counts, start clears them
    step(8'h01, 8'h00, 1'b1);
    check("restart_not_done", done, 0);
    check("restart_hits_held", hit_count, 2);
    check("restart_misses_held", miss_count, 2);
    step(8'h2c, 8'h00, 1'b1);
    check("start_clears", {hit_count, miss_count}, 0);

    // Second keycode slot scores on its own edge
    steer_to(320);
    step(8'h00, 8'h51, 1'b1);
    check("second_key_hit", hit, 1);
    check("second_key_count", hit_count, 1);
    step(8'h00, 8'h00, 1'b1);

    // Reset mid-fall
    steer_to(250);
    step(8'h00, 8'h00, 1'b0);
    check("midrst_visible", visible, 0);
    check("midrst_dropY", dropY, 100);
    check("midrst_counts", {hit_count, miss_count}, 0);
    check("midrst_pulses", {hit, miss}, 0);

    // Randomized traffic against the model
    k1 = 8'h00;
    k2 = 8'h00;
    for (int i = 0; i < 9000; i++) begin
      if ($urandom_range(0, 9) < 3) k1 = pick_key();
      if ($urandom_range(0, 9) < 2) k2 = pick_key();
      rn = ($urandom_range(0, 1499) != 0);
      step(k1, k2, rn);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
